// File: rtl/rc4_pkg.sv
// Shared types and default constants for the RC4 key-search controller.
package rc4_pkg;

    localparam int               KEY_W     = 24;
    localparam logic [KEY_W-1:0] KEY_FIRST = 24'h000000;
    localparam logic [KEY_W-1:0] KEY_LAST  = 24'h3FFFFF;
    localparam int               TIMEOUT   = 4096;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT      = 3'd2,
        ST_FOUND     = 3'd3,
        ST_EXHAUSTED = 3'd4,
        ST_ERROR     = 3'd5
    } search_state_t;

endpackage

// File: rtl/rc4_wait_watchdog.sv
// Cycle watchdog for the WAIT phase: counts enabled cycles and flags expiry
// on the TIMEOUT-th enabled cycle since the last clear.
module rc4_wait_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;

    // Expiry is a decode of the count so the FSM can leave WAIT on the same edge.
    assign expired = enable && (count_reg == CNT_W'(TIMEOUT - 1));

    // Count enabled cycles; hold once expired so the count never wraps.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/rc4_search_ctrl.sv
// Sequencing controller for the RC4 brute-force key search. Walks a key
// range, launches one attempt per key on the core, and reports the outcome.
module rc4_search_ctrl
    import rc4_pkg::*;
#(
    parameter int               KEY_W     = rc4_pkg::KEY_W,
    parameter logic [KEY_W-1:0] KEY_FIRST = rc4_pkg::KEY_FIRST,
    parameter logic [KEY_W-1:0] KEY_LAST  = rc4_pkg::KEY_LAST,
    parameter int               TIMEOUT   = rc4_pkg::TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             restart,
    input  logic             core_ready,
    input  logic             core_done,
    input  logic             core_match,
    output logic             core_start,
    output logic [KEY_W-1:0] key,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic             error
);

    generate
        if (KEY_FIRST > KEY_LAST) begin : g_bad_key_range
            $error("rc4_search_ctrl: KEY_FIRST must not exceed KEY_LAST");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("rc4_search_ctrl: TIMEOUT must be at least 1");
        end
    endgenerate

    search_state_t    state_reg, state_next;
    logic [KEY_W-1:0] key_reg, key_next;
    logic             wd_clear;
    logic             wd_enable;
    logic             wd_expired;

    // Watchdog restarts in LAUNCH so it reads zero on the first WAIT cycle;
    // a cycle carrying core_done is not counted against the attempt.
    assign wd_clear  = restart || (state_reg == ST_LAUNCH);
    assign wd_enable = (state_reg == ST_WAIT) && !core_done;

    rc4_wait_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Next-state and key-advance logic; restart overrides everything.
    always_comb begin
        state_next = state_reg;
        key_next   = key_reg;
        case (state_reg)
            ST_IDLE: begin
                if (run && core_ready) begin
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    if (core_match) begin
                        state_next = ST_FOUND;
                    end else if (key_reg == KEY_LAST) begin
                        state_next = ST_EXHAUSTED;
                    end else begin
                        key_next   = key_reg + 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (wd_expired) begin
                    state_next = ST_ERROR;
                end
            end
            ST_FOUND, ST_EXHAUSTED, ST_ERROR: begin
                state_next = state_reg;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (restart) begin
            state_next = ST_IDLE;
            key_next   = KEY_FIRST;
        end
    end

    // State and key registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            key_reg   <= KEY_FIRST;
        end else begin
            state_reg <= state_next;
            key_reg   <= key_next;
        end
    end

    // Outputs are pure decodes of registered state, so they are glitch-free.
    assign key        = key_reg;
    assign core_start = (state_reg == ST_LAUNCH);
    assign busy       = (state_reg == ST_LAUNCH) || (state_reg == ST_WAIT);
    assign found      = (state_reg == ST_FOUND);
    assign exhausted  = (state_reg == ST_EXHAUSTED);
    assign error      = (state_reg == ST_ERROR);

endmodule
